// File: rtl/sgd_tree_pkg.sv
// Shared types for the adder-tree scheduler: lane/vector types, tree geometry and the
// owner tag that travels alongside each chunk through the tree.
package sgd_tree_pkg;

    localparam int LANES    = 9;
    localparam int TREE_LAT = 2;
    localparam int TAG_ID_W = 8;

    typedef logic signed [31:0] lane_t;
    typedef lane_t [LANES-1:0] vec_t;

    // Id field is wide enough for any practical requester count; users narrow it on read.
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/sgd_adder_tree_sched_if.sv
// Bundle of requester, tree and result signals of the adder-tree scheduler.
// master = environment (engines, tree, loss stage); slave = scheduler.
interface sgd_adder_tree_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = 2,
    parameter int CNT_W   = 16
) ();
    import sgd_tree_pkg::*;

    logic [CNT_W-1:0]        cfg_chunks;
    vec_t [NUM_REQ-1:0]      req_data;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    vec_t                    tree_in;
    logic                    tree_in_valid;
    lane_t                   tree_out;
    logic                    tree_out_valid;
    lane_t                   res_data;
    logic [REQ_W-1:0]        res_id;
    logic                    res_valid;
    logic                    busy;
    logic                    err;

    modport master (
        output cfg_chunks, req_data, req_valid, tree_out, tree_out_valid,
        input  req_ready, tree_in, tree_in_valid, res_data, res_id, res_valid, busy, err
    );

    modport slave (
        input  cfg_chunks, req_data, req_valid, tree_out, tree_out_valid,
        output req_ready, tree_in, tree_in_valid, res_data, res_id, res_valid, busy, err
    );

endinterface

// File: rtl/sgd_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from rr_ptr,
// pointer moves past the winner on every grant.
module sgd_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [REQ_W-1:0]   grant_id,
    output logic               grant_valid
);

    logic [REQ_W-1:0] rr_ptr;
    logic [REQ_W-1:0] idx;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        grant_oh    = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = REQ_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
        if (grant_valid) grant_oh[grant_id] = 1'b1;
    end

    // A grant is always a transfer: only a valid requester can win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= (grant_id == REQ_W'(NUM_REQ - 1)) ? '0 : grant_id + REQ_W'(1);
        end
    end

endmodule

// File: rtl/sgd_adder_tree_sched.sv
// Shares one pipelined 9-lane adder tree between NUM_REQ dot-product engines: issues one
// chunk per cycle, tags it with its owner, and accumulates returned sums per owner.
module sgd_adder_tree_sched
    import sgd_tree_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    sgd_adder_tree_sched_if.slave bus
);

    logic [NUM_REQ-1:0] grant_oh;
    logic [REQ_W-1:0]   grant_id;
    logic               grant_valid;

    sgd_rr_arbiter #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (bus.req_valid),
        .grant_oh    (grant_oh),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    assign bus.req_ready = grant_oh;

    vec_t             tree_in_q;
    logic             tree_in_valid_q;
    logic [REQ_W-1:0] issue_id_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tree_in_q       <= '0;
            tree_in_valid_q <= 1'b0;
            issue_id_q      <= '0;
        end else begin
            tree_in_valid_q <= grant_valid;
            if (grant_valid) begin
                tree_in_q  <= bus.req_data[grant_id];
                issue_id_q <= grant_id;
            end
        end
    end

    assign bus.tree_in       = tree_in_q;
    assign bus.tree_in_valid = tree_in_valid_q;

    // Tag pipe is fed from the issue register, so its last stage lines up with tree_out_valid.
    tag_t tag_q [TREE_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TREE_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{valid: tree_in_valid_q, id: TAG_ID_W'(issue_id_q)};
            for (int i = 1; i < TREE_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    tag_t             ret;
    logic [REQ_W-1:0] ret_id;
    logic [CNT_W-1:0] last;

    assign ret    = tag_q[TREE_LAT-1];
    assign ret_id = REQ_W'(ret.id);
    assign last   = (bus.cfg_chunks == '0) ? '0 : bus.cfg_chunks - CNT_W'(1);

    lane_t            acc [NUM_REQ];
    logic [CNT_W-1:0] cnt [NUM_REQ];
    lane_t            res_data_q;
    logic [REQ_W-1:0] res_id_q;
    logic             res_valid_q;
    logic             err_q;

    // NOTE: the per-requester accumulators are plain flops, not RAM, so they are cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            if (bus.tree_out_valid != ret.valid) err_q <= 1'b1;
            if (bus.tree_out_valid && ret.valid) begin
                if (cnt[ret_id] == last) begin
                    res_data_q  <= acc[ret_id] + bus.tree_out;
                    res_id_q    <= ret_id;
                    res_valid_q <= 1'b1;
                    acc[ret_id] <= '0;
                    cnt[ret_id] <= '0;
                end else begin
                    acc[ret_id] <= acc[ret_id] + bus.tree_out;
                    cnt[ret_id] <= cnt[ret_id] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_valid = res_valid_q;
    assign bus.err       = err_q;

    // The issue register counts as an in-flight tag too.
    always_comb begin
        bus.busy = tree_in_valid_q;
        for (int i = 0; i < NUM_REQ; i++) bus.busy = bus.busy | (cnt[i] != '0);
        for (int i = 0; i < TREE_LAT; i++) bus.busy = bus.busy | tag_q[i].valid;
    end

endmodule
